// File: rtl/full_adder_pkg.sv
// Shared constants and the arithmetic golden model for the registered
// ripple-carry full adder.
package full_adder_pkg;

    // Default operand width: the classic 1-bit full adder.
    localparam int DEFAULT_WIDTH = 1;

    // Widest operand the reference function can handle.
    localparam int REF_MAX_W = 64;

    // Golden {cout,sum} for operands zero-extended to REF_MAX_W bits.
    // For operands narrower than W bits, bits [W:0] of the result hold
    // {cout,sum} for a W-bit add.
    function automatic logic [REF_MAX_W:0] ref_add(
        input logic [REF_MAX_W-1:0] a,
        input logic [REF_MAX_W-1:0] b,
        input logic                 c
    );
        return {1'b0, a} + {1'b0, b} + {{REF_MAX_W{1'b0}}, c};
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full-adder cell, one link of the ripple chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum is the parity of the three inputs. Carry is their majority.
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {Cout,Sum} = A + B + C, one-cycle latency,
// valid-tagged, with no backpressure.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             out_valid
);

    // carry[i] is the carry into bit i. carry[WIDTH] is the carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = C;

    // One cell per bit. The carry ripples from the LSB up to the MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (sum_comb[i]),
            .co (carry[i+1])
        );
    end

    // Capture the result on accepted inputs. Otherwise hold it. Reset wins.
    always_ff @(posedge clk) begin
        // NOTE: Use non-blocking assignments for all flops so every register samples pre-edge values.
        if (!rst_n) begin
            Sum       <= '0;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum  <= sum_comb;
                Cout <= carry[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 and WIDTH=8. Expected values
// come from plain integer arithmetic and the package golden function.
module tb_full_adder;
    import full_adder_pkg::*;

    logic       clk;
    logic       rst_n;

    logic       in_valid1;
    logic [0:0] a1, b1;
    logic       c1;
    logic [0:0] sum1;
    logic       cout1, ov1;

    logic       in_valid8;
    logic [7:0] a8, b8;
    logic       c8;
    logic [7:0] sum8;
    logic       cout8, ov8;

    int n_tests;
    int n_fail;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .A         (a1),
        .B         (b1),
        .C         (c1),
        .Sum       (sum1),
        .Cout      (cout1),
        .out_valid (ov1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .A         (a8),
        .B         (b8),
        .C         (c8),
        .Sum       (sum8),
        .Cout      (cout8),
        .out_valid (ov8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are checked and inputs are driven on the falling edge, away from capture.
    task automatic tick();
        @(negedge clk);
    endtask

    logic [1:0]         exp1;
    logic [8:0]         exp8;
    logic [8:0]         exp_q;
    logic [REF_MAX_W:0] golden;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;

        // Reset state after two edges.
        tick(); tick();
        check("rst_sum1", 64'(sum1), 64'd0);
        check("rst_cout1", 64'(cout1), 64'd0);
        check("rst_ov1", 64'(ov1), 64'd0);
        check("rst_sum8", 64'(sum8), 64'd0);
        check("rst_ov8", 64'(ov8), 64'd0);

        // Reset overrides in_valid for two edges.
        in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        tick(); tick();
        check("rst_ovr_sum", 64'(sum1), 64'd0);
        check("rst_ovr_cout", 64'(cout1), 64'd0);
        check("rst_ovr_ov", 64'(ov1), 64'd0);

        // Release: the next accepted input 1+1+1 gives Cout=1, Sum=1.
        rst_n = 1'b1;
        tick();
        check("post_rst_res", 64'({cout1, sum1}), 64'b11);
        check("post_rst_ov", 64'(ov1), 64'd1);

        // WIDTH=1 exhaustive truth table.
        for (int k = 0; k < 8; k++) begin
            {a1, b1, c1} = 3'(k);
            in_valid1    = 1'b1;
            exp1         = {1'b0, a1} + {1'b0, b1} + {1'b0, c1};
            tick();
            check($sformatf("tt%0d_res", k), 64'({cout1, sum1}), 64'(exp1));
            check($sformatf("tt%0d_ov", k), 64'(ov1), 64'd1);
        end

        // Hold: result 1+1+0 stays put while in_valid=0, with new and X inputs.
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; in_valid1 = 1'b1;
        tick();
        check("hold_cap_res", 64'({cout1, sum1}), 64'b10);
        check("hold_cap_ov", 64'(ov1), 64'd1);
        in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b1;
        tick();
        check("hold1_res", 64'({cout1, sum1}), 64'b10);
        check("hold1_ov", 64'(ov1), 64'd0);
        a1 = 'x; b1 = 'x; c1 = 'x;
        tick();
        check("hold2_res", 64'({cout1, sum1}), 64'b10);
        check("hold2_ov", 64'(ov1), 64'd0);
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;

        // WIDTH=8 wrap-around cases.
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; in_valid8 = 1'b1;
        tick();
        check("wrap1_sum", 64'(sum8), 64'h00);
        check("wrap1_cout", 64'(cout8), 64'd1);
        check("wrap1_ov", 64'(ov8), 64'd1);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        tick();
        check("wrap2_sum", 64'(sum8), 64'hFF);
        check("wrap2_cout", 64'(cout8), 64'd1);
        check("wrap2_ov", 64'(ov8), 64'd1);

        // 1000 back-to-back random vectors. Each result is checked one cycle later.
        for (int i = 0; i < 1000; i++) begin
            a8        = 8'($urandom);
            b8        = 8'($urandom);
            c8        = 1'($urandom);
            in_valid8 = 1'b1;
            golden    = ref_add(64'(a8), 64'(b8), c8);
            exp_q     = golden[8:0];
            tick();
            check("rnd_sum", 64'(sum8), 64'(exp_q[7:0]));
            check("rnd_cout", 64'(cout8), 64'(exp_q[8]));
            check("rnd_ov", 64'(ov8), 64'd1);
        end

        // Hold at WIDTH=8 with X on the data inputs.
        in_valid8 = 1'b0; a8 = 'x; b8 = 'x; c8 = 'x;
        tick();
        check("hold8_sum", 64'(sum8), 64'(exp_q[7:0]));
        check("hold8_cout", 64'(cout8), 64'(exp_q[8]));
        check("hold8_ov", 64'(ov8), 64'd0);

        // Accept 0x12+0x34, then reset on the following edge.
        a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; in_valid8 = 1'b1;
        exp8 = 9'h012 + 9'h034;
        tick();
        check("mid_acc_sum", 64'(sum8), 64'(exp8[7:0]));
        check("mid_acc_ov", 64'(ov8), 64'd1);
        rst_n = 1'b0; in_valid8 = 1'b0;
        tick();
        check("mid_rst_sum", 64'(sum8), 64'h00);
        check("mid_rst_cout", 64'(cout8), 64'd0);
        check("mid_rst_ov", 64'(ov8), 64'd0);

        // Reset on the same edge as an accept discards that accept.
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b1; in_valid8 = 1'b1;
        tick();
        check("same_edge_sum", 64'(sum8), 64'h00);
        check("same_edge_ov", 64'(ov8), 64'd0);

        // After release, out_valid stays low until a new accept.
        rst_n = 1'b1; in_valid8 = 1'b0;
        tick();
        check("post_rst8_ov", 64'(ov8), 64'd0);
        check("post_rst8_sum", 64'(sum8), 64'h00);
        check("post_rst8_cout", 64'(cout8), 64'd0);
        tick();
        check("post_rst8_ov2", 64'(ov8), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
